// File: rtl/timer_pkg.sv
// Shared definitions for the mm:ss countdown timer: FSM states, time limits
// and the preset saturation helper.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;

  // Clamp a 6-bit preset to the given upper limit.
  function automatic logic [5:0] sat_limit(input logic [5:0] value,
                                           input logic [5:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles; the
// count is forced back to zero whenever en is low.
module tick_prescaler #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mmss_countdown.sv
// Minutes:seconds countdown timer with load/start/stop/clear pulse controls,
// a one-cycle expired pulse and a level alarm held in DONE.
module mmss_countdown
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       expired,
  output logic       alarm
);

  state_t     state;
  logic       presc_en;
  logic       tick;
  logic [5:0] nxt_min;
  logic [5:0] nxt_sec;
  logic       hits_zero;
  logic       time_nonzero;

  // Dropping enable on the stop/clear cycle both suppresses a coincident
  // tick and zeroes the prescaler on the same edge the state leaves RUN.
  assign presc_en = (state == ST_RUN) && !clear && !stop;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (presc_en),
    .tick  (tick)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    nxt_min = min;
    nxt_sec = sec;
    if (sec != 6'd0) begin
      nxt_sec = sec - 6'd1;
    end else if (min != 6'd0) begin
      nxt_min = min - 6'd1;
      nxt_sec = MAX_SEC;
    end
  end

  assign hits_zero    = (nxt_min == 6'd0) && (nxt_sec == 6'd0);
  assign time_nonzero = (min != 6'd0) || (sec != 6'd0);
  assign running      = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      min     <= 6'd0;
      sec     <= 6'd0;
      expired <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (clear) begin
        state <= ST_IDLE;
        min   <= 6'd0;
        sec   <= 6'd0;
        alarm <= 1'b0;
      end else if (load && state != ST_RUN) begin
        state <= ST_IDLE;
        min   <= sat_limit(load_min, MAX_MIN);
        sec   <= sat_limit(load_sec, MAX_SEC);
        alarm <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_PAUSE: begin
            if (start && time_nonzero) begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (stop) begin
              state <= ST_PAUSE;
            end else if (tick) begin
              min <= nxt_min;
              sec <= nxt_sec;
              if (hits_zero) begin
                state   <= ST_DONE;
                expired <= 1'b1;
                alarm   <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            // Start cannot restart from 00:00; it only acknowledges the alarm.
            if (start) begin
              alarm <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmss_countdown.sv
// Self-checking bench for mmss_countdown: directed scenarios plus random
// pulse traffic compared against a remaining-seconds reference model.
module tb_mmss_countdown;

  localparam int TD = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       stop;
  logic       clear;
  logic [5:0] min;
  logic [5:0] sec;
  logic       running;
  logic       expired;
  logic       alarm;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining time in whole seconds, a mode, and the number
  // of uninterrupted RUN cycles since the last decrement.
  int m_total;
  int m_mode;
  int m_phase;
  bit m_alarm;
  bit m_expired;

  mmss_countdown #(
    .TICK_DIV (TD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .min      (min),
    .sec      (sec),
    .running  (running),
    .expired  (expired),
    .alarm    (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp59(input int v);
    return (v > 59) ? 59 : v;
  endfunction

  task automatic model_reset();
    m_total   = 0;
    m_mode    = M_IDLE;
    m_phase   = 0;
    m_alarm   = 1'b0;
    m_expired = 1'b0;
  endtask

  task automatic model_step(input bit ld, input int lm, input int ls,
                            input bit st, input bit sp, input bit cl);
    m_expired = 1'b0;
    if (cl) begin
      m_total = 0;
      m_mode  = M_IDLE;
      m_phase = 0;
      m_alarm = 1'b0;
    end else if (ld && m_mode != M_RUN) begin
      m_total = clamp59(lm) * 60 + clamp59(ls);
      m_mode  = M_IDLE;
      m_phase = 0;
      m_alarm = 1'b0;
    end else if (sp && m_mode == M_RUN) begin
      m_mode  = M_PAUSE;
      m_phase = 0;
    end else if (st && (m_mode == M_IDLE || m_mode == M_PAUSE) && m_total > 0) begin
      m_mode  = M_RUN;
      m_phase = 0;
    end else if (st && m_mode == M_DONE) begin
      m_alarm = 1'b0;
    end else if (m_mode == M_RUN) begin
      m_phase++;
      if (m_phase == TD) begin
        m_phase = 0;
        m_total--;
        if (m_total == 0) begin
          m_mode    = M_DONE;
          m_expired = 1'b1;
          m_alarm   = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".min"},     32'(min),     32'(m_total / 60));
    check({tag, ".sec"},     32'(sec),     32'(m_total % 60));
    check({tag, ".running"}, 32'(running), 32'(m_mode == M_RUN));
    check({tag, ".expired"}, 32'(expired), 32'(m_expired));
    check({tag, ".alarm"},   32'(alarm),   32'(m_alarm));
  endtask

  // Drive one cycle's pulses shortly after a rising edge, let the DUT sample
  // them on the next edge, step the model, then compare 1 time unit later.
  task automatic cycle(input string tag, input bit ld, input int lm, input int ls,
                       input bit st, input bit sp, input bit cl);
    load     = ld;
    load_min = 6'(lm);
    load_sec = 6'(ls);
    start    = st;
    stop     = sp;
    clear    = cl;
    @(posedge clk);
    model_step(ld, lm, ls, st, sp, cl);
    #1;
    compare_all(tag);
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, ".rst_min"},     32'(min),     32'd0);
    check({tag, ".rst_sec"},     32'(sec),     32'd0);
    check({tag, ".rst_running"}, 32'(running), 32'd0);
    check({tag, ".rst_expired"}, 32'(expired), 32'd0);
    check({tag, ".rst_alarm"},   32'(alarm),   32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    load_min = 6'd0;
    load_sec = 6'd0;
    start    = 1'b0;
    stop     = 1'b0;
    clear    = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_reset", 2);

    // 01:02 counts down through the minute borrow, one step per TD cycles.
    cycle("ld0102", 1, 1, 2, 0, 0, 0);
    cycle("st0102", 0, 0, 0, 1, 0, 0);
    idle("run0102", TD);
    check("dir.0101_sec", 32'(sec), 32'd1);
    idle("run0102", TD);
    check("dir.0100_min", 32'(min), 32'd1);
    idle("run0102", TD);
    check("dir.0059_min", 32'(min), 32'd0);
    check("dir.0059_sec", 32'(sec), 32'd59);
    check("dir.0059_run", 32'(running), 32'd1);

    // 00:02 expires with a single expired pulse and a held alarm.
    cycle("clr", 0, 0, 0, 0, 0, 1);
    cycle("ld0002", 1, 0, 2, 0, 0, 0);
    cycle("st0002", 0, 0, 0, 1, 0, 0);
    idle("run0002", 2 * TD);
    check("dir.exp_pulse", 32'(expired), 32'd1);
    check("dir.exp_alarm", 32'(alarm), 32'd1);
    idle("done", 3);
    check("dir.exp_once", 32'(expired), 32'd0);
    check("dir.alarm_held", 32'(alarm), 32'd1);
    check("dir.done_norun", 32'(running), 32'd0);
    cycle("done_start", 0, 0, 0, 1, 0, 0);
    check("dir.start_ack", 32'(alarm), 32'd0);

    // Oversized presets saturate; start at 00:00 is ignored.
    cycle("ld6363", 1, 63, 63, 0, 0, 0);
    check("dir.sat_min", 32'(min), 32'd59);
    check("dir.sat_sec", 32'(sec), 32'd59);
    cycle("clr", 0, 0, 0, 0, 0, 1);
    cycle("st_zero", 0, 0, 0, 1, 0, 0);
    idle("st_zero", 2);
    check("dir.zero_norun", 32'(running), 32'd0);

    // Stop on the tick cycle holds 00:05; resume decrements TD cycles later.
    cycle("ld0005", 1, 0, 5, 0, 0, 0);
    cycle("st0005", 0, 0, 0, 1, 0, 0);
    idle("run0005", TD - 1);
    cycle("stop_tick", 0, 0, 0, 0, 1, 0);
    check("dir.stop_tick_sec", 32'(sec), 32'd5);
    idle("paused", 5);
    cycle("resume", 0, 0, 0, 1, 0, 0);
    idle("resume", TD - 1);
    check("dir.resume_early", 32'(sec), 32'd5);
    idle("resume", 1);
    check("dir.resume_sec", 32'(sec), 32'd4);

    // Clear wins over load and start arriving together in PAUSE.
    cycle("pause", 0, 0, 0, 0, 1, 0);
    cycle("cls", 1, 7, 7, 1, 0, 1);
    check("dir.cls_sec", 32'(sec), 32'd0);
    idle("cls", 3);
    check("dir.cls_norun", 32'(running), 32'd0);

    // Asynchronous reset mid-RUN at 00:30.
    cycle("ld0031", 1, 0, 31, 0, 0, 0);
    cycle("st0031", 0, 0, 0, 1, 0, 0);
    idle("run0031", TD + 1);
    check("dir.at_0030", 32'(sec), 32'd30);
    async_reset("midrun");
    idle("after_rst", 2 * TD + 2);

    // Random pulse traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      bit cl, ld, st, sp;
      int lm, ls;
      cl = ($urandom_range(0, 99) < 2);
      ld = ($urandom_range(0, 99) < 5);
      st = ($urandom_range(0, 99) < 12);
      sp = ($urandom_range(0, 99) < 4);
      lm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 1));
      ls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 5));
      cycle("rnd", ld, lm, ls, st, sp, cl);
      if ($urandom_range(0, 499) == 0) async_reset("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
